hls_deadlock_report_ctrl: RTL and testbench
===========================================

# hls_deadlock_report_ctrl

Top-level controller that collects the `block` outputs of the per-instance HLS deadlock monitors and qualifies each one with a persistence counter. When any monitor has reported block for THRESHOLD consecutive cycles, the controller selects one index by round-robin, latches a report, and presents it on a valid/ready interface for the debug/status path. It sits above the monitor tree in the generated accelerator wrapper, one instance per chiplet.

## Interface

- NUM_MON, 4: number of monitor `block` inputs; at least 1.
- THRESHOLD, 64: consecutive blocked cycles required to confirm a monitor; at least 1.
- HOLDOFF_CYCLES, 16: idle cycles after an acknowledged report before a new capture; 0 allowed.
- IDX_W, derived: max(1, $clog2(NUM_MON)).
- CNT_W, derived: $clog2(THRESHOLD+1).

- clock  in  1  single clock domain.
- reset  in  1  synchronous, active-high.
- mon_block  in  NUM_MON  raw `block` outputs of the monitors, bit i = monitor i.
- enable  in  1  detection enable.
- rpt_valid  out  1  a report is pending.
- rpt_ready  in  1  consumer accepts the report.
- rpt_idx  out  IDX_W  monitor selected for this report.
- rpt_mask  out  NUM_MON  all monitors confirmed at capture.
- deadlock  out  1  high from capture until the report is accepted.
- rpt_cycle  out  32  cycle stamp of the capture. Present only with the macro described under Configuration.

## Operation

- Persistence counters, one per monitor, registered:
  - If `mon_block[i] && enable`, the counter increments and saturates at THRESHOLD.
  - Otherwise it clears to 0.
  - `confirmed[i] = (cnt[i] == THRESHOLD)`.
- Round-robin pointer `rr_ptr` (IDX_W bits) resets to 0.
- FSM states: IDLE, REPORT, HOLDOFF.
- IDLE:
  - If any `confirmed` bit is set, capture the report and go to REPORT.
  - `rpt_mask <= confirmed`.
  - `rpt_idx <=` the first confirmed index found from `rr_ptr` upward, wrapping modulo NUM_MON.
  - `deadlock <= 1`.
- REPORT:
  - `rpt_valid = 1`. `rpt_idx`, `rpt_mask`, `deadlock` and `rpt_cycle` stay stable until the handshake.
  - Handshake is `rpt_valid && rpt_ready`. On the handshake:
    - `rr_ptr <= (rpt_idx+1) mod NUM_MON`.
    - `deadlock <= 0`.
    - The counters of every monitor in `rpt_mask` clear to 0, overriding any increment that cycle.
    - Load the holdoff counter with HOLDOFF_CYCLES, then go to HOLDOFF. If HOLDOFF_CYCLES == 0, go straight to IDLE.
  - `rpt_mask` and `rpt_idx` keep their values after the handshake; only `rpt_valid` drops.
- HOLDOFF:
  - The holdoff counter decrements each cycle; go to IDLE when it reaches 1.
  - Persistence counters keep running, so a monitor can be confirmed again once holdoff ends.
- Enable low:
  - All persistence counters clear.
  - A pending REPORT is not aborted; it completes normally on the handshake.
- Simultaneous events:
  - When several monitors confirm in the same cycle, all of them appear in `rpt_mask` and only the round-robin winner appears in `rpt_idx`.
  - A monitor whose block drops during REPORT does not change the latched report.
- Reset, including mid-REPORT:
  - The FSM goes to IDLE and all counters and `rr_ptr` clear.
  - `rpt_valid`, `rpt_idx`, `rpt_mask`, `deadlock` and `rpt_cycle` reset to 0 on the next edge.

## Timing

- Take cycle 0 as the first cycle in which `mon_block[i]=1` is sampled. Then:
  - `cnt[i] == THRESHOLD` in cycle THRESHOLD.
  - `rpt_valid` and `deadlock` are high from cycle THRESHOLD+1.
  - Detection latency is exactly THRESHOLD+1 cycles.
- `rpt_valid` depends on no combinational path from `rpt_ready`; all outputs are registered.
- Handshake in cycle H:
  - `rpt_valid = 0` and `deadlock = 0` from cycle H+1.
  - With HOLDOFF_CYCLES > 0, the earliest next `rpt_valid` is cycle H+HOLDOFF_CYCLES+2.

## Configuration

- `DEADLOCK_TIMESTAMP_EN`, when defined:
  - Adds a free-running 32-bit cycle counter, cleared by reset and wrapping at 2^32.
  - Adds the `rpt_cycle` port, which captures the counter value at the capture edge.
- When not defined, neither the counter nor the `rpt_cycle` port exists. All other behaviour is identical.

## Test plan

Common parameters: NUM_MON=4, THRESHOLD=8, HOLDOFF_CYCLES=4.

- `mon_block=4'b0100` held from cycle 0 with `rpt_ready=0` -> `rpt_valid`/`deadlock` rise in cycle 9 with `rpt_idx=2` and `rpt_mask=0100`; outputs stay stable for 20 cycles.
- `mon_block[1]` high for 7 cycles, low for 1 cycle, then high again -> no report until 9 cycles after the re-rise.
- `mon_block=4'b1011` held, `rpt_ready=1` -> successive reports give `rpt_idx` 0, 1, 3, 0 with `rpt_mask=1011` each time and a gap of 4 holdoff cycles between reports.
- Report pending, then `enable=0` and `mon_block=0` -> report stays valid, completes on `rpt_ready`, and no new report follows.
- `reset` pulsed for 1 cycle during REPORT -> all outputs 0 on the next cycle, and re-detection again takes 9 cycles.
- With `DEADLOCK_TIMESTAMP_EN` defined and `mon_block[0]` raised at cycle 100 after reset release -> `rpt_cycle=108`.

Source files
------------

// File: rtl/hls_deadlock_report_ctrl.sv
// hls_deadlock_report_ctrl: qualifies monitor block flags by persistence and reports one deadlocked monitor round-robin
// Ports: clock, reset (sync, active-high), mon_block[NUM_MON], enable, rpt_ready in;
//        rpt_valid, rpt_idx, rpt_mask, deadlock out; rpt_cycle out only when DEADLOCK_TIMESTAMP_EN is defined
//        (adds a free-running 32-bit cycle counter whose value is latched at capture).
module hls_deadlock_report_ctrl #(
  parameter int NUM_MON = 4,
  parameter int THRESHOLD = 64,
  parameter int HOLDOFF_CYCLES = 16,
  localparam int IDX_W = NUM_MON > 1 ? $clog2(NUM_MON) : 1,
  localparam int CNT_W = $clog2(THRESHOLD + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               enable,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic [NUM_MON-1:0] rpt_mask,
  output logic               deadlock
`ifdef DEADLOCK_TIMESTAMP_EN
  ,
  output logic [31:0]        rpt_cycle
`endif
);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 2);
  typedef enum logic [1:0] {IDLE, REPORT, HOLDOFF} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt [NUM_MON];
  logic [NUM_MON-1:0] confirmed;
  logic [IDX_W-1:0] rr_ptr, sel;
  logic [HW-1:0] hold;
  logic hs, capture;
  int best;
  assign hs = rpt_valid && rpt_ready;
  assign capture = state == IDLE && |confirmed;
  genvar i;
  for (i = 0; i < NUM_MON; i++) begin : g_cnt
    // the acknowledged monitors restart from zero even if still blocked
    always_ff @(posedge clock)
      cnt[i] <= reset || (hs && rpt_mask[i]) || !(mon_block[i] && enable) ? '0
              : confirmed[i] ? cnt[i] : cnt[i] + CNT_W'(1);
    assign confirmed[i] = cnt[i] == CNT_W'(THRESHOLD);
  end
  // winner is the confirmed monitor at the smallest wrapped distance from rr_ptr
  always_comb begin
    sel = '0;
    best = NUM_MON;
    for (int k = 0; k < NUM_MON; k++)
      if (confirmed[k] && (k + NUM_MON - int'(rr_ptr)) % NUM_MON < best) begin
        best = (k + NUM_MON - int'(rr_ptr)) % NUM_MON;
        sel = IDX_W'(k);
      end
  end
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state == IDLE   ? (|confirmed ? REPORT : IDLE)
              : state == REPORT ? (rpt_ready ? (HOLDOFF_CYCLES == 0 ? IDLE : HOLDOFF) : REPORT)
              : (hold <= HW'(1) ? IDLE : HOLDOFF);
  end
  always_comb begin
    rpt_valid = state == REPORT;
    deadlock = state == REPORT;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
      hold <= '0;
      rpt_idx <= '0;
      rpt_mask <= '0;
    end else begin
      if (capture) begin
        rpt_idx <= sel;
        rpt_mask <= confirmed;
      end
      if (hs) rr_ptr <= int'(rpt_idx) == NUM_MON - 1 ? '0 : rpt_idx + IDX_W'(1);
      hold <= hs ? HW'(HOLDOFF_CYCLES) : state == HOLDOFF ? hold - HW'(1) : hold;
    end
  end
`ifdef DEADLOCK_TIMESTAMP_EN
  logic [31:0] cyc;
  always_ff @(posedge clock) begin
    cyc <= reset ? '0 : cyc + 32'd1;
    rpt_cycle <= reset ? '0 : capture ? cyc : rpt_cycle;
  end
`endif
endmodule

// File: tb/tb_hls_deadlock_report_ctrl.sv
// tb_hls_deadlock_report_ctrl: directed and randomized checks of the deadlock report controller
module tb_hls_deadlock_report_ctrl;
  localparam int N = 4, TH = 8, HO = 4;
  logic clock = 0, reset = 1, enable = 0, rpt_ready = 0;
  logic [3:0] mon_block = '0;
  logic rpt_valid, deadlock;
  logic [1:0] rpt_idx;
  logic [3:0] rpt_mask;
  logic [7:0] dvec;
`ifdef DEADLOCK_TIMESTAMP_EN
  logic [31:0] rpt_cycle;
`endif
  int total = 0, bad = 0;
  int run [N];
  bit m_valid = 0;
  logic [1:0] m_idx = '0;
  logic [3:0] m_mask = '0;
  int m_ptr = 0, m_hold = 0;
  logic [31:0] m_t = '0, m_cycle = '0;

  always #5 clock = ~clock;
  assign dvec = {rpt_valid, deadlock, rpt_idx, rpt_mask};

  hls_deadlock_report_ctrl #(.NUM_MON(N), .THRESHOLD(TH), .HOLDOFF_CYCLES(HO)) dut (
    .clock(clock),
    .reset(reset),
    .mon_block(mon_block),
    .enable(enable),
    .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready),
    .rpt_idx(rpt_idx),
    .rpt_mask(rpt_mask),
    .deadlock(deadlock)
`ifdef DEADLOCK_TIMESTAMP_EN
    ,
    .rpt_cycle(rpt_cycle)
`endif
  );

  function automatic logic [7:0] mvec();
    return {m_valid, m_valid, m_idx, m_mask};
  endfunction

  // Reference model: run[i] is the length of the current blocked run, a report is
  // pending or not, and m_hold counts the quiet edges remaining after an acknowledge.
  task automatic tick();
    logic [3:0] conf;
    bit hs;
    for (int k = 0; k < N; k++) conf[k] = run[k] >= TH;
    hs = m_valid && rpt_ready;
    if (reset) begin
      m_valid = 0; m_idx = '0; m_mask = '0; m_ptr = 0; m_hold = 0; m_t = '0; m_cycle = '0;
      for (int k = 0; k < N; k++) run[k] = 0;
    end else begin
      if (m_valid) begin
        if (hs) begin
          m_valid = 0;
          m_ptr = (int'(m_idx) + 1) % N;
          m_hold = HO;
        end
      end else if (m_hold > 0) m_hold--;
      else if (conf != 0) begin
        m_valid = 1;
        m_mask = conf;
        m_cycle = m_t;
        for (int o = N - 1; o >= 0; o--)
          if (conf[(m_ptr + o) % N]) m_idx = 2'((m_ptr + o) % N);
      end
      for (int k = 0; k < N; k++)
        run[k] = (hs && m_mask[k]) ? 0 : (mon_block[k] && enable) ? (run[k] < TH ? run[k] + 1 : TH) : 0;
      m_t++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; enable = 0; mon_block = '0; rpt_ready = 0;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; enable = 1; mon_block = 4'b1111; rpt_ready = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      total++;
      if (dvec !== 8'd0) begin bad++; $display("FAIL reset_outputs: got %b want %b", dvec, 8'd0); end
    end
    reset = 0;
  endtask

  task automatic test_single();
    do_reset();
    enable = 1; mon_block = 4'b0100;
    for (int n = 1; n <= 29; n++) begin
      tick();
      total++;
      if (dvec !== mvec()) begin bad++; $display("FAIL single_model: cycle %0d got %b want %b", n, dvec, mvec()); end
      total++;
      if (n < 9 && dvec[7:6] !== 2'b00) begin bad++; $display("FAIL single_early: cycle %0d got %b want 00", n, dvec[7:6]); end
      else if (n >= 9 && dvec !== 8'b11_10_0100) begin bad++; $display("FAIL single_report: cycle %0d got %b want 11100100", n, dvec); end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    enable = 1; mon_block = 4'b0010;
    for (int n = 0; n < 7; n++) tick();
    mon_block = '0;
    tick();
    total++;
    if (rpt_valid !== 1'b0) begin bad++; $display("FAIL glitch_gap: got %b want 0", rpt_valid); end
    mon_block = 4'b0010;
    for (int n = 1; n <= 12; n++) begin
      tick();
      total++;
      if (rpt_valid !== (n >= 9)) begin bad++; $display("FAIL glitch_rerise: cycle %0d got %b want %b", n, rpt_valid, n >= 9); end
      total++;
      if (dvec !== mvec()) begin bad++; $display("FAIL glitch_model: got %b want %b", dvec, mvec()); end
    end
  endtask

  task automatic test_rr();
    int exp_idx [4] = '{0, 1, 3, 0};
    int k = 0, last = 0;
    do_reset();
    enable = 1; mon_block = 4'b1011; rpt_ready = 1;
    for (int n = 1; n <= 45; n++) begin
      tick();
      total++;
      if (dvec !== mvec()) begin bad++; $display("FAIL rr_model: cycle %0d got %b want %b", n, dvec, mvec()); end
      if (rpt_valid) begin
        total++;
        if (k < 4 && ({rpt_idx, rpt_mask} !== {2'(exp_idx[k]), 4'b1011}))
          begin bad++; $display("FAIL rr_report%0d: got idx=%0d mask=%b want idx=%0d mask=1011", k, rpt_idx, rpt_mask, exp_idx[k]); end
        total++;
        if (n - last !== (k == 0 ? 9 : 10)) begin bad++; $display("FAIL rr_gap%0d: got %0d want %0d", k, n - last, k == 0 ? 9 : 10); end
        last = n;
        k++;
      end
    end
    total++;
    if (k !== 4) begin bad++; $display("FAIL rr_count: got %0d want 4", k); end
    rpt_ready = 0;
  endtask

  task automatic test_enable_drop();
    do_reset();
    enable = 1; mon_block = 4'b0001;
    for (int n = 0; n < 9; n++) tick();
    total++;
    if (dvec !== 8'b11_00_0001) begin bad++; $display("FAIL en_report: got %b want 11000001", dvec); end
    enable = 0; mon_block = '0;
    for (int n = 0; n < 5; n++) begin
      tick();
      total++;
      if (dvec !== 8'b11_00_0001) begin bad++; $display("FAIL en_hold: got %b want 11000001", dvec); end
    end
    rpt_ready = 1;
    for (int n = 0; n < 20; n++) begin
      tick();
      total++;
      if (dvec !== 8'b00_00_0001) begin bad++; $display("FAIL en_after: got %b want 00000001", dvec); end
      total++;
      if (dvec !== mvec()) begin bad++; $display("FAIL en_model: got %b want %b", dvec, mvec()); end
    end
    rpt_ready = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1; mon_block = 4'b1000;
    for (int n = 0; n < 9; n++) tick();
    total++;
    if (dvec !== 8'b11_11_1000) begin bad++; $display("FAIL rmid_report: got %b want 11111000", dvec); end
    reset = 1;
    tick();
    reset = 0;
    total++;
    if (dvec !== 8'd0) begin bad++; $display("FAIL rmid_clear: got %b want 00000000", dvec); end
    for (int n = 1; n <= 9; n++) begin
      tick();
      total++;
      if (rpt_valid !== (n == 9)) begin bad++; $display("FAIL rmid_redetect: cycle %0d got %b want %b", n, rpt_valid, n == 9); end
    end
  endtask

`ifdef DEADLOCK_TIMESTAMP_EN
  task automatic test_timestamp();
    bit seen = 0;
    do_reset();
    enable = 1;
    for (int n = 0; n < 100; n++) tick();
    mon_block = 4'b0001;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (rpt_valid) begin seen = 1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL ts_timeout: got no report want report"); end
    total++;
    if (rpt_cycle !== 32'd108) begin bad++; $display("FAIL ts_cycle: got %0d want 108", rpt_cycle); end
    total++;
    if (rpt_cycle !== m_cycle) begin bad++; $display("FAIL ts_model: got %0d want %0d", rpt_cycle, m_cycle); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(0, 399) == 0;
      enable = $urandom_range(0, 15) != 0;
      for (int k = 0; k < N; k++) mon_block[k] = $urandom_range(0, 7) != 0;
      rpt_ready = $urandom_range(0, 3) == 0;
      tick();
      total++;
      if (dvec !== mvec()) begin bad++; $display("FAIL random_model: step %0d got %b want %b", n, dvec, mvec()); end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_rr();
    test_enable_drop();
    test_reset_mid();
`ifdef DEADLOCK_TIMESTAMP_EN
    test_timestamp();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
